// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited in-order word
// requests, buffers returned words for decode and drives R15 (next_pc).
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] next_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard_cnt;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   buf_instr [FIFO_DEPTH];
  logic [31:0]   buf_pc    [FIFO_DEPTH];

  logic          issue;
  logic          resp;
  logic          push;
  logic          pop;
  logic [CW:0]   in_use;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    next_ptr = (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshakes: a transfer happens only in a cycle where both valid (req/rvalid)
  // and ready (gnt/instr_ready) are high; valid never depends on ready.
  // Every issued request reserves a buffer slot, so the buffer cannot overflow.
  assign in_use   = {1'b0, outstanding} + {1'b0, count};
  assign imem_req = rst_n && !redirect && (in_use < (CW+1)'(FIFO_DEPTH));
  assign issue    = imem_req && imem_gnt;
  assign resp     = imem_rvalid && (outstanding != '0);
  assign push     = resp && (discard_cnt == '0) && !redirect;
  assign pop      = instr_valid && instr_ready && !redirect;

  assign imem_addr   = fetch_pc;
  assign next_pc     = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr       = buf_instr[rd_ptr];
  assign instr_pc    = buf_pc[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (redirect) begin
      // Everything still in flight (minus a response landing now) must be dropped.
      fetch_pc    <= redirect_pc & ~32'h3;
      resp_pc     <= redirect_pc & ~32'h3;
      outstanding <= outstanding - CW'(resp);
      discard_cnt <= outstanding - CW'(resp);
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (issue) fetch_pc <= fetch_pc + 32'd4;
      outstanding <= outstanding + CW'(issue) - CW'(resp);
      if (resp && (discard_cnt != '0)) discard_cnt <= discard_cnt - 1'b1;
      if (push) begin
        resp_pc <= resp_pc + 32'd4;
        wr_ptr  <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= imem_rdata;
      buf_pc[wr_ptr]    <= resp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model, expected-PC scoreboard,
// immediate assertions at every comparison point.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] next_pc;

  int          total = 0;
  int          bad = 0;
  int          n_issue = 0;
  logic        hold = 1'b0;
  logic [31:0] pend_q[$];
  logic [31:0] exp_q[$];

  fetch_unit #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .next_pc(next_pc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    mem_word = a ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: score any pop, advance, then let the memory answer in order.
  task automatic tick();
    logic        did_issue;
    logic [31:0] a;
    logic [31:0] e;
    #1;
    did_issue = imem_req && imem_gnt;
    a = imem_addr;
    if (instr_valid && instr_ready && !redirect && rst_n) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_pop observed=%h expected=none", instr_pc);
      end else begin
        e = exp_q.pop_front();
        chk("pop_pc", instr_pc, e);
        chk("pop_data", instr, mem_word(e));
      end
    end
    @(posedge clk);
    #1;
    redirect = 1'b0;
    if (did_issue) begin
      pend_q.push_back(a);
      n_issue++;
    end
    if (!hold && pend_q.size() != 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_0100);
    chk("rst_next_pc", next_pc, 32'h0000_0100);
    exp_q.delete();
    n_issue = 0;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    instr_ready = 1'b1;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    instr_ready = 1'b0;
    chk(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;

    // 1: straight-line fetch after reset
    do_reset();
    chk("t1_req", {31'd0, imem_req}, 32'd1);
    chk("t1_addr0", imem_addr, 32'h0000_0100);
    chk("t1_npc0", next_pc, 32'h0000_0100);
    exp_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
    tick();
    chk("t1_addr1", imem_addr, 32'h0000_0104);
    chk("t1_npc1", next_pc, 32'h0000_0104);
    chk("t1_valid1", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("t1_valid2", {31'd0, instr_valid}, 32'd1);
    chk("t1_pc2", instr_pc, 32'h0000_0100);
    chk("t1_data2", instr, mem_word(32'h100));
    chk("t1_credit", {31'd0, imem_req}, 32'd0);
    drain("t1_drain");

    // 2: decode stalled, credit stops issue at two
    instr_ready = 1'b0;
    do_reset();
    tick();
    tick();
    chk("t2_req_c", {31'd0, imem_req}, 32'd0);
    chk("t2_pc_c", instr_pc, 32'h0000_0100);
    tick();
    chk("t2_req_d", {31'd0, imem_req}, 32'd0);
    chk("t2_pc_d", instr_pc, 32'h0000_0100);
    tick();
    chk("t2_issues", n_issue, 32'd2);
    chk("t2_pc_e", instr_pc, 32'h0000_0100);
    exp_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
    instr_ready = 1'b1;
    tick();
    chk("t2_resume_req", {31'd0, imem_req}, 32'd1);
    chk("t2_resume_addr", imem_addr, 32'h0000_0108);
    chk("t2_resume_pc", instr_pc, 32'h0000_0104);
    drain("t2_drain");

    // 3: redirect with two requests in flight
    do_reset();
    hold = 1'b1;
    instr_ready = 1'b1;
    tick();
    tick();
    chk("t3_inflight", n_issue, 32'd2);
    chk("t3_req_blocked", {31'd0, imem_req}, 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'h0000_2003;
    tick();
    chk("t3_addr", imem_addr, 32'h0000_2000);
    chk("t3_npc", next_pc, 32'h0000_2000);
    chk("t3_valid_d", {31'd0, instr_valid}, 32'd0);
    hold = 1'b0;
    exp_q = '{32'h2000, 32'h2004};
    tick();
    chk("t3_valid_e", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("t3_valid_f", {31'd0, instr_valid}, 32'd0);
    chk("t3_req_f", {31'd0, imem_req}, 32'd1);
    chk("t3_addr_f", imem_addr, 32'h0000_2000);
    drain("t3_drain");

    // 4: redirect together with a response and a pop
    do_reset();
    hold = 1'b1;
    instr_ready = 1'b0;
    tick();
    tick();
    hold = 1'b0;
    tick();
    hold = 1'b1;
    tick();
    chk("t4_head", instr_pc, 32'h0000_0100);
    chk("t4_req", {31'd0, imem_req}, 32'd0);
    hold = 1'b0;
    tick();
    hold = 1'b1;
    chk("t4_rvalid", {31'd0, imem_rvalid}, 32'd1);
    instr_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_3000;
    tick();
    chk("t4_flushed", {31'd0, instr_valid}, 32'd0);
    chk("t4_req_new", {31'd0, imem_req}, 32'd1);
    chk("t4_addr_new", imem_addr, 32'h0000_3000);
    hold = 1'b0;
    exp_q = '{32'h3000, 32'h3004};
    drain("t4_drain");

    // 5: address wrap at the top of memory
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    tick();
    chk("t5_addr", imem_addr, 32'hFFFF_FFF8);
    drain("t5_drain");

    // 6: reset with requests in flight; late responses must be ignored
    do_reset();
    hold = 1'b1;
    instr_ready = 1'b0;
    tick();
    tick();
    chk("t6_inflight", n_issue, 32'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    imem_gnt = 1'b0;
    hold = 1'b0;
    exp_q.delete();
    tick();
    chk("t6_valid_r2", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("t6_valid_r3", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("t6_valid_r4", {31'd0, instr_valid}, 32'd0);
    chk("t6_addr_r4", imem_addr, 32'h0000_0100);
    imem_gnt = 1'b1;
    exp_q = '{32'h100, 32'h104, 32'h108};
    drain("t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
